des_key_sched_rev: RTL and testbench
====================================

# des_key_sched_rev

Sequential DES decryption key scheduler. It accepts the 56-bit post-PC-1 key (C0‖D0) and emits the sixteen 48-bit round keys in reverse order, K16 first and K1 last. It undoes the encryption schedule by rotating each 28-bit half right by 0, 1 or 2 bits per step. It sits between the key register and the round datapath of the decrypt engine, and hands keys over with a valid/ready handshake.

## Interface

**Parameters**
- none: the DES schedule is fixed.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: load `key_cd` and begin a schedule. Sampled only in IDLE.
- `key_cd` input 56: C0 in bits [55:28], D0 in bits [27:0], already PC-1 permuted.
- `busy` output 1: high while the block is in RUN.
- `k_valid` output 1: `k_out` holds a valid round key.
- `k_ready` input 1: the consumer accepts `k_out` this cycle.
- `k_out` output 48: PC-2 (FIPS 46-3) of the current C‖D register.
- `k_idx` output 4: subkey number of `k_out`. 16 is encoded as 4'd0; 15..1 are encoded as themselves.
- `cd_out` output 56: current C‖D register, for debug and verification.
- `done` output 1: one-cycle pulse after K1 has been accepted.

## Operation

**Registers**
- `cd_q` [55:0]
- `j` [4:0], emission step 1..16
- `state` ∈ {IDLE, RUN}
- `done_q`

**Reset (`rst_n` low, any time, including mid-schedule)**
- `state` = IDLE, `cd_q` = 0, `j` = 0, `done` = 0.
- `k_valid` = 0, `busy` = 0, `k_idx` = 0.
- `k_out` = PC-2(0) = 0.
- Any partially emitted schedule is lost; the next key needs a new `start`.

**IDLE**
- `start` = 1: `cd_q` ← `key_cd`, `j` ← 1, go to RUN. No rotation is applied on load (step 1 uses C16D16 = C0D0).
- `start` = 0: hold.

**RUN**
- `k_valid` = 1, `busy` = 1. `k_idx` = 17 − `j`, taken modulo 16.
- Handshake = `k_valid` & `k_ready`.
- No handshake: `cd_q`, `j` and `k_out` stay stable. Stall length is unbounded.
- Handshake with `j` < 16:
  - `j` ← `j` + 1.
  - `cd_q` ← each half rotated right by g(`j` + 1), where g(n) = 1 for n ∈ {2, 9, 16} and g(n) = 2 for all other n in 3..15.
  - Right rotation by 1: bit 27 ← bit 0 of the half. By 2: bits [27:26] ← bits [1:0].
  - The two halves rotate independently; no bit crosses the C/D boundary.
- Handshake with `j` = 16: go to IDLE, `done_q` ← 1 for exactly one cycle. `cd_q` keeps C1D1.
- `start` during RUN is ignored and does not restart the schedule.

**Invariants**
- Cumulative right rotation across the schedule is 0+1+2·6+1+2·6+1 = 27.
- A further rotr-1 of C1D1 equals C0D0.

**DONE cycle**
- The block is in IDLE, so `start` asserted in the same cycle as `done` is accepted.

## Timing

- `start` sampled at edge t: `k_valid` high and `k_out` = K16 from edge t+1.
- With `k_ready` held at 1, one key per cycle: K16..K1 across cycles t+1..t+16, `done` at t+17.
- Minimum start-to-start spacing is 17 cycles.
- `k_out` is combinational PC-2 of `cd_q` only, with no path from `k_ready` or `start`. It changes only on a clock edge after a handshake or load.
- `k_valid`, `busy` and `done` are registered-state decodes, glitch-free with respect to the inputs.
- `k_valid` never deasserts without a handshake, except on reset.

## Test plan

- **Golden key.** Key 133457799BBCDFF1, so `key_cd` = F0CCAAF_556678F. `start` with `k_ready` = 1 gives:
  - `k_out` = CB3D8B0E17F5 with `k_idx` = 0 (K16) at t+1.
  - K2 = 79AED9DBC9E5 at t+15.
  - K1 = 1B02EFFC7072 at t+16.
  - `done` at t+17.
- **Reference model.** 50 random `key_cd` values, with `k_ready` held high. The 16 `k_out` values must equal a software encryption schedule in reverse. Final `cd_out` rotated right by 1 per half must equal `key_cd`.
- **Backpressure.** Golden key with `k_ready` random at 30 % duty.
  - `k_out`, `k_idx` and `cd_out` stay constant across every stall.
  - Exactly 16 handshakes occur.
  - `done` pulses once.
- **Busy start.** Pulse `start` with a different key at steps 3 and 16. The sequence is unaffected and all golden values match.
- **Reset mid-schedule.** Drop `rst_n` asynchronously after K12 is accepted.
  - All outputs go to 0 immediately.
  - After release, `k_valid` stays 0 until `start`.
  - A new `start` yields CB3D8B0E17F5 first.
- **Back-to-back.** Assert `start` in the `done` cycle. The second schedule's K16 appears in the next cycle, with no idle gap beyond the `done` cycle.

Source files
------------

// File: rtl/des_key_sched_rev.sv
// DES decryption key scheduler.
// Loads the PC-1 permuted key C0||D0 and presents the round keys K16 down to K1.
// Each key is handed to the round datapath over a valid/ready handshake.
// After each accepted key, both 28-bit halves rotate right by the encryption
// shift that is being undone. The halves rotate independently of each other.
module des_key_sched_rev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [55:0] key_cd,
    output logic        busy,
    output logic        k_valid,
    input  logic        k_ready,
    output logic [47:0] k_out,
    output logic [3:0]  k_idx,
    output logic [55:0] cd_out,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-2 selection table (FIPS 46-3). Entries are 1-based and count from the MSB of C||D.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [55:0] cd_q;
    logic [4:0]  j;
    logic        done_q;
    logic        hs;
    logic [4:0]  idx_full;

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2[i]];
        end
        return r;
    endfunction

    // The shift undone at step n is 1 for rounds 2, 9 and 16, and 2 for the other steps.
    function automatic logic shift_two(input logic [4:0] n);
        return !((n == 5'd2) || (n == 5'd9) || (n == 5'd16));
    endfunction

    function automatic logic [27:0] rotr_half(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
        return {rotr_half(cd[55:28], two), rotr_half(cd[27:0], two)};
    endfunction

    // Handshake qualifier and the subkey number for the current step (17 - j, modulo 16).
    always_comb begin
        hs       = (state == RUN) && k_ready;
        idx_full = 5'd17 - j;
    end

    assign busy    = (state == RUN);
    assign k_valid = (state == RUN);
    assign k_idx   = (state == RUN) ? idx_full[3:0] : 4'd0;
    assign k_out   = pc2(cd_q);
    assign cd_out  = cd_q;
    assign done    = done_q;

    // Schedule FSM: load on start, step the key register on each accepted key, and pulse done after K1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cd_q   <= '0;
            j      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cd_q  <= key_cd;
                        j     <= 5'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (j == 5'd16) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            j    <= j + 5'd1;
                            cd_q <= rotr_cd(cd_q, shift_two(j + 5'd1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Testbench for des_key_sched_rev. It uses a forward DES key schedule model and
// checks the DUT on every cycle.
module tb_des_key_sched_rev;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [55:0] key_cd;
    logic        busy;
    logic        k_valid;
    logic        k_ready;
    logic [47:0] k_out;
    logic [3:0]  k_idx;
    logic [55:0] cd_out;
    logic        done;

    int nchecks = 0;
    int nerr    = 0;

    localparam logic [55:0] GOLD = 56'hF0CCAAF556678F;
    localparam logic [47:0] GK16 = 48'hCB3D8B0E17F5;
    localparam logic [47:0] GK2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] GK1  = 48'h1B02EFFC7072;

    // Left-shift amounts of the encryption schedule for rounds 1..16.
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    des_key_sched_rev dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .key_cd  (key_cd),
        .busy    (busy),
        .k_valid (k_valid),
        .k_ready (k_ready),
        .k_out   (k_out),
        .k_idx   (k_idx),
        .cd_out  (cd_out),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
        return (x << s) | (x >> (28 - s));
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // C_i||D_i of the forward encryption schedule.
    function automatic logic [55:0] model_cd(input logic [55:0] cd0, input int i);
        logic [27:0] c;
        logic [27:0] d;
        c = cd0[55:28];
        d = cd0[27:0];
        for (int r = 1; r <= i; r++) begin
            c = rotl28(c, SH[r-1]);
            d = rotl28(d, SH[r-1]);
        end
        return {c, d};
    endfunction

    function automatic logic [47:0] model_key(input logic [55:0] cd0, input int i);
        return pc2(model_cd(cd0, i));
    endfunction

    function automatic logic [55:0] rotr1_cd(input logic [55:0] cd);
        return {cd[28], cd[55:29], cd[0], cd[27:1]};
    endfunction

    typedef struct packed {
        logic [47:0] k;
        logic [3:0]  idx;
        logic [55:0] cd;
    } ent_t;

    ent_t q[$];
    logic mdone = 1'b0;

    function automatic void push_sched(input logic [55:0] cd0);
        ent_t e;
        for (int i = 16; i >= 1; i--) begin
            e.k   = model_key(cd0, i);
            e.idx = 4'(i % 16);
            e.cd  = model_cd(cd0, i);
            q.push_back(e);
        end
    endfunction

    // Per-cycle compare against the model, followed by the model update for the next edge.
    always @(negedge clk) begin
        logic nd;
        if (!rst_n) begin
            q.delete();
            mdone = 1'b0;
            chk("rst k_valid", 64'(k_valid), 64'd0);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst done", 64'(done), 64'd0);
            chk("rst k_out", 64'(k_out), 64'd0);
            chk("rst k_idx", 64'(k_idx), 64'd0);
            chk("rst cd_out", 64'(cd_out), 64'd0);
        end else begin
            chk("k_valid", 64'(k_valid), 64'(q.size() != 0));
            chk("busy", 64'(busy), 64'(q.size() != 0));
            chk("done", 64'(done), 64'(mdone));
            if (q.size() != 0) begin
                chk("k_out", 64'(k_out), 64'(q[0].k));
                chk("k_idx", 64'(k_idx), 64'(q[0].idx));
                chk("cd_out", 64'(cd_out), 64'(q[0].cd));
            end
            nd = 1'b0;
            if (q.size() != 0) begin
                if (k_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) nd = 1'b1;
                end
            end else if (start) begin
                push_sched(key_cd);
            end
            mdone = nd;
        end
    end

    task automatic start_key(input logic [55:0] k);
        @(posedge clk); #1;
        start  = 1'b1;
        key_cd = k;
        @(posedge clk); #1;
        start  = 1'b0;
        key_cd = ~k;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (c < budget) begin
            @(negedge clk);
            if (done) break;
            c++;
        end
        chk("done within budget", 64'(c < budget), 64'd1);
    endtask

    // Golden key with k_ready held high. Optionally pulse start while busy, or chain a second key in the done cycle.
    task automatic golden_run(input bit pulse, input bit b2b, input logic [55:0] key2);
        k_ready = 1'b1;
        start_key(GOLD);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("gold K16", 64'(k_out), 64'(GK16));
                chk("gold K16 idx", 64'(k_idx), 64'd0);
            end
            if (n == 15) chk("gold K2", 64'(k_out), 64'(GK2));
            if (n == 16) begin
                chk("gold K1", 64'(k_out), 64'(GK1));
                chk("gold K1 idx", 64'(k_idx), 64'd1);
            end
            if (n == 17) chk("gold done", 64'(done), 64'd1);
            @(posedge clk); #1;
            start  = (pulse && (n + 1 == 3 || n + 1 == 16)) || (b2b && n + 1 == 17);
            key_cd = (b2b && n + 1 == 17) ? key2 : ~GOLD;
        end
        if (b2b) begin
            @(negedge clk);
            chk("b2b k_valid", 64'(k_valid), 64'd1);
            chk("b2b K16", 64'(k_out), 64'(model_key(key2, 16)));
            wait_done(40);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [55:0] k;
        int hs;
        int dn;
        int post;

        rst_n  = 1'b0;
        start  = 1'b0;
        k_ready = 1'b0;
        key_cd = '0;
        #22 rst_n = 1'b1;

        // Pin the model to the published schedule of the golden key.
        chk("model K16", 64'(model_key(GOLD, 16)), 64'(GK16));
        chk("model K2", 64'(model_key(GOLD, 2)), 64'(GK2));
        chk("model K1", 64'(model_key(GOLD, 1)), 64'(GK1));
        chk("model C16D16", 64'(model_cd(GOLD, 16)), 64'(GOLD));

        idle(2);
        golden_run(1'b0, 1'b0, '0);
        idle(2);

        // Starts issued while busy must be ignored.
        golden_run(1'b1, 1'b0, '0);
        idle(2);

        // Random keys with k_ready held high.
        k_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            r = {$urandom, $urandom};
            k = r[55:0];
            start_key(k);
            wait_done(40);
            chk("final cd rotr1", 64'(rotr1_cd(cd_out)), 64'(k));
            idle(1);
        end

        // Backpressure: k_ready asserted at a 30 % duty cycle.
        k_ready = 1'b0;
        start_key(GOLD);
        hs = 0;
        dn = 0;
        post = 0;
        for (int c = 0; c < 600; c++) begin
            k_ready = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            if (k_valid && k_ready) hs++;
            if (done) dn++;
            if (dn > 0) begin
                post++;
                if (post > 3) break;
            end
            @(posedge clk); #1;
        end
        chk("bp handshakes", 64'(hs), 64'd16);
        chk("bp done pulses", 64'(dn), 64'd1);
        k_ready = 1'b1;
        idle(2);

        // Asynchronous reset after K12 has been accepted.
        start_key(GOLD);
        for (int n = 1; n <= 5; n++) @(negedge clk);
        chk("pre-reset K12 idx", 64'(k_idx), 64'd12);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async k_valid", 64'(k_valid), 64'd0);
        chk("async busy", 64'(busy), 64'd0);
        chk("async done", 64'(done), 64'd0);
        chk("async k_out", 64'(k_out), 64'd0);
        chk("async k_idx", 64'(k_idx), 64'd0);
        chk("async cd_out", 64'(cd_out), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(5);
        golden_run(1'b0, 1'b0, '0);
        idle(2);

        // Back-to-back: the second start lands in the done cycle.
        r = {$urandom, $urandom};
        golden_run(1'b0, 1'b1, r[55:0]);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
